lif_neuron: RTL and testbench

Leaky integrate-and-fire neuron that sits directly downstream of the 25-input spike-gated MAC. It consumes one 21-bit weighted sum per timestep and maintains a saturating membrane potential that leaks by a right-shift each timestep. When the potential reaches a runtime threshold, the block emits a one-cycle spike and holds the neuron refractory for a fixed number of timesteps. A saturating spike counter provides the per-image firing rate to the classifier/readout stage.

---
 rtl/snn_pkg.sv | 14 +
 rtl/sat_add_leak.sv | 40 ++++
 rtl/lif_neuron.sv | 94 +++++++++
 tb/tb_lif_neuron.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and width defaults for the SNN datapath (MAC -> LIF neuron).
package snn_pkg;

    // The MAC's weighted-sum width; the neuron's potential is wider for headroom.
    localparam int SNN_SUM_W = 21;
    localparam int SNN_POT_W = 24;

    // Neuron control state: integrating samples, or ignoring them after a spike.
    typedef enum logic {
        LIF_INTEG  = 1'b0,
        LIF_REFRAC = 1'b1
    } lif_state_t;

endpackage

// File: rtl/sat_add_leak.sv
// Combinational membrane update: pot - (pot >> LEAK_SHIFT) + sum, clamped to POT_W bits.
module sat_add_leak
    import snn_pkg::*;
#(
    parameter int SUM_W      = SNN_SUM_W,
    parameter int POT_W      = SNN_POT_W,
    parameter int LEAK_SHIFT = 4
) (
    input  logic [POT_W-1:0] pot_i,
    input  logic [SUM_W-1:0] sum_i,
    output logic [POT_W-1:0] next_o
);

    logic [POT_W:0] pot_w;
    logic [POT_W:0] leak_w;
    logic [POT_W:0] sum_w;
    logic [POT_W:0] acc_w;

    assign pot_w = {1'b0, pot_i};
    assign sum_w = (POT_W+1)'(sum_i);

    // A shift of zero would drain the whole potential, so it means "no leak".
    generate
        if (LEAK_SHIFT == 0) begin : g_noleak
            assign leak_w = '0;
        end else begin : g_leak
            assign leak_w = pot_w >> LEAK_SHIFT;
        end
    endgenerate

    // Leak never exceeds pot, so only the add can overflow; one extra bit catches it.
    assign acc_w = pot_w - leak_w + sum_w;

    // Clamp at all-ones instead of wrapping to a small potential.
    always_comb begin
        next_o = acc_w[POT_W-1:0];
        if (acc_w[POT_W]) next_o = '1;
    end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with refractory period and saturating spike counter.
module lif_neuron
    import snn_pkg::*;
#(
    parameter int SUM_W      = SNN_SUM_W,
    parameter int POT_W      = SNN_POT_W,
    parameter int LEAK_SHIFT = 4,
    parameter int REFRAC     = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             sum_valid,
    input  logic             clear,
    input  logic [POT_W-1:0] threshold,
    output logic             spike_out,
    output logic [POT_W-1:0] potential,
    output logic             refractory,
    output logic [CNT_W-1:0] spike_count
);

    localparam int RC_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    lif_state_t       state_q;
    logic [RC_W-1:0]  rcnt_q;
    logic [POT_W-1:0] pot_q;
    logic [POT_W-1:0] pot_d;
    logic [CNT_W-1:0] cnt_q;
    logic             spike_q;
    logic             fire;

    sat_add_leak #(
        .SUM_W      (SUM_W),
        .POT_W      (POT_W),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_dp (
        .pot_i  (pot_q),
        .sum_i  (sum_in),
        .next_o (pot_d)
    );

    assign fire = (pot_d >= threshold);

    // Neuron FSM: integrate/fire in INTEG, drop samples in REFRAC; clear beats sum_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LIF_INTEG;
            rcnt_q  <= '0;
            pot_q   <= '0;
            cnt_q   <= '0;
            spike_q <= 1'b0;
        end else if (clear) begin
            state_q <= LIF_INTEG;
            rcnt_q  <= '0;
            pot_q   <= '0;
            cnt_q   <= '0;
            spike_q <= 1'b0;
        end else begin
            // Spike is a pulse: it only survives the cycle it was produced in.
            spike_q <= 1'b0;
            if (sum_valid) begin
                case (state_q)
                    LIF_INTEG: begin
                        if (fire) begin
                            spike_q <= 1'b1;
                            pot_q   <= '0;
                            if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
                            if (REFRAC != 0) begin
                                rcnt_q  <= RC_W'(REFRAC);
                                state_q <= LIF_REFRAC;
                            end
                        end else begin
                            pot_q <= pot_d;
                        end
                    end
                    LIF_REFRAC: begin
                        // Sample is discarded; leave on the edge that eats the last one.
                        pot_q  <= '0;
                        rcnt_q <= rcnt_q - 1'b1;
                        if (rcnt_q <= RC_W'(1)) state_q <= LIF_INTEG;
                    end
                    default: state_q <= LIF_INTEG;
                endcase
            end
        end
    end

    assign spike_out   = spike_q;
    assign potential   = pot_q;
    assign refractory  = (state_q == LIF_REFRAC);
    assign spike_count = cnt_q;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron: main instance with defaults, plus a CNT_W=2/REFRAC=0 instance.
module tb_lif_neuron;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [20:0] sum_in = '0;
    logic        sum_valid = 1'b0;
    logic        clear = 1'b0;
    logic [23:0] threshold = 24'd1000;
    logic        spike_out;
    logic [23:0] potential;
    logic        refractory;
    logic [7:0]  spike_count;

    // Counter-saturation instance
    logic [20:0] c_sum = '0;
    logic        c_valid = 1'b0;
    logic        c_clear = 1'b0;
    logic [23:0] c_thr = '0;
    logic        c_spike;
    logic [23:0] c_pot;
    logic        c_refr;
    logic [1:0]  c_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lif_neuron #(.SUM_W(21), .POT_W(24), .LEAK_SHIFT(4), .REFRAC(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .sum_valid(sum_valid), .clear(clear),
        .threshold(threshold), .spike_out(spike_out), .potential(potential),
        .refractory(refractory), .spike_count(spike_count)
    );

    lif_neuron #(.SUM_W(21), .POT_W(24), .LEAK_SHIFT(4), .REFRAC(0), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .sum_in(c_sum), .sum_valid(c_valid), .clear(c_clear),
        .threshold(c_thr), .spike_out(c_spike), .potential(c_pot),
        .refractory(c_refr), .spike_count(c_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs to the main instance, sample #1 after the edge.
    task automatic step(input logic v, input logic [20:0] s, input logic clr);
        @(negedge clk);
        sum_valid = v;
        sum_in    = s;
        clear     = clr;
        @(posedge clk);
        #1;
        sum_valid = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic cstep(input logic v);
        @(negedge clk);
        c_valid = v;
        c_sum   = 21'd7;
        @(posedge clk);
        #1;
        c_valid = 1'b0;
    endtask

    initial begin
        logic [24:0] m;
        logic [24:0] w;
        bit          fired;

        // Reset held while valid samples arrive: nothing may move.
        step(1'b1, 21'd500, 1'b0);
        step(1'b1, 21'd500, 1'b0);
        chk("rst_pot", 32'(potential), 0);
        chk("rst_spike", 32'(spike_out), 0);
        chk("rst_refr", 32'(refractory), 0);
        chk("rst_cnt", 32'(spike_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 21'd500, 1'b0);
        chk("first_pot", 32'(potential), 500);
        chk("first_spike", 32'(spike_out), 0);

        // Idle cycle: no leak without a valid
        step(1'b0, 21'd0, 1'b0);
        chk("idle_hold", 32'(potential), 500);

        // Leak: 500 - 31 = 469
        step(1'b1, 21'd0, 1'b0);
        chk("leak_pot", 32'(potential), 469);
        // 469 - 29 + 600 = 1040 -> fire
        step(1'b1, 21'd600, 1'b0);
        chk("fire_spike", 32'(spike_out), 1);
        chk("fire_pot", 32'(potential), 0);
        chk("fire_refr", 32'(refractory), 1);
        chk("fire_cnt", 32'(spike_count), 1);
        step(1'b0, 21'd0, 1'b0);
        chk("pulse_width", 32'(spike_out), 0);
        chk("refr_hold_idle", 32'(refractory), 1);

        // Refractory: two dropped samples
        step(1'b1, 21'd2000, 1'b0);
        chk("ref1_pot", 32'(potential), 0);
        chk("ref1_spike", 32'(spike_out), 0);
        chk("ref1_refr", 32'(refractory), 1);
        step(1'b1, 21'd2000, 1'b0);
        chk("ref2_pot", 32'(potential), 0);
        chk("ref2_spike", 32'(spike_out), 0);
        chk("ref2_refr", 32'(refractory), 0);
        step(1'b1, 21'd2000, 1'b0);
        chk("ref3_spike", 32'(spike_out), 1);
        chk("ref3_cnt", 32'(spike_count), 2);
        chk("ref3_refr", 32'(refractory), 1);

        // Clear beats a simultaneous valid while refractory
        step(1'b1, 21'd5000, 1'b1);
        chk("clr_pot", 32'(potential), 0);
        chk("clr_cnt", 32'(spike_count), 0);
        chk("clr_refr", 32'(refractory), 0);
        chk("clr_spike", 32'(spike_out), 0);
        step(1'b1, 21'd500, 1'b0);
        chk("clr_next_pot", 32'(potential), 500);

        // Potential saturation: only a clamped value can reach 0xFFFFFF
        step(1'b0, 21'd0, 1'b1);
        threshold = 24'hFFFFFF;
        m = '0;
        fired = 1'b0;
        for (int i = 0; i < 40 && !fired; i++) begin
            step(1'b1, 21'h1FFFFF, 1'b0);
            w = m - (m >> 4) + 25'h1FFFFF;
            if (w > 25'hFFFFFF) w = 25'hFFFFFF;
            if (w == 25'hFFFFFF) begin
                fired = 1'b1;
                chk("sat_spike", 32'(spike_out), 1);
                chk("sat_pot", 32'(potential), 0);
                chk("sat_cnt", 32'(spike_count), 1);
            end else begin
                chk("sat_ramp_pot", 32'(potential), 32'(w));
                chk("sat_ramp_spike", 32'(spike_out), 0);
                m = w;
            end
        end
        chk("sat_reached", 32'(fired), 1);
        threshold = 24'd1000;

        // Counter saturation on the 2-bit, no-refractory instance
        for (int i = 0; i < 5; i++) begin
            cstep(1'b1);
            chk("cnt_spike", 32'(c_spike), 1);
            chk("cnt_val", 32'(c_cnt), (i < 3) ? i + 1 : 3);
            chk("cnt_refr", 32'(c_refr), 0);
            cstep(1'b0);
            chk("cnt_pulse_low", 32'(c_spike), 0);
        end

        // Asynchronous reset mid-operation
        step(1'b0, 21'd0, 1'b1);
        step(1'b1, 21'd700, 1'b0);
        chk("pre_arst_pot", 32'(potential), 700);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pot", 32'(potential), 0);
        chk("arst_cnt", 32'(c_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 21'd300, 1'b0);
        chk("post_arst_pot", 32'(potential), 300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
